data_memory_pipe: RTL
=====================

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block accepts a request this cycle.
REQ-008 SHALL have port opcode  in  4  instruction opcode; OP_LOAD selects memory read data.
REQ-009 SHALL have port mem_we  in  1  store: write wdata to addr.
REQ-010 SHALL have port addr  in  ADDR_W  word address.
REQ-011 SHALL have port wdata  in  DATA_W  store data.
REQ-012 SHALL have port alu_result  in  DATA_W  passthrough result for non-load opcodes.
REQ-013 SHALL have ports dest_reg  in  3, reg_we  in  1: writeback tag and enable, carried with request.
REQ-014 SHALL have ports rsp_valid  out  1, rsp_data  out  DATA_W, rsp_dest  out  3, rsp_reg_we  out  1: registered response.
REQ-015 SHALL have port init_busy  out  1  high while memory initialisation runs.

Function
REQ-016 SHALL implement FSM states INIT and RUN; reset forces INIT with init counter 0.
REQ-017 In INIT with reset low, SHALL write init value to word[counter] each cycle, increment counter, and move to RUN after writing word DEPTH-1 (DEPTH cycles total).
REQ-018 SHALL drive init_busy = (state==INIT) and req_ready = (state==RUN).
REQ-019 Request accepted iff req_valid && req_ready; non-accepted cycles cause no write and rsp_valid=0 next cycle.
REQ-020 Accepted request SHALL produce rsp_valid=1 exactly one cycle later, with rsp_dest/rsp_reg_we equal to captured dest_reg/reg_we.
REQ-021 rsp_data SHALL be word[addr] when opcode==OP_LOAD, else captured alu_result.
REQ-022 Accepted store (mem_we=1) SHALL update word[addr] at that clock edge; load in same request returns pre-write data.
REQ-023 Load issued the cycle after a store to the same address SHALL return the stored data.
REQ-024 addr >= DEPTH: store ignored, load returns 0.
REQ-025 Back-to-back accepted requests SHALL sustain one response per cycle with no bubbles.

Reset
REQ-026 Reset high SHALL force rsp_valid=0, rsp_data=0, rsp_dest=0, rsp_reg_we=0, req_ready=0, init_busy=1 next cycle.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL discard any in-flight response and restart initialisation from word 0.

Configuration
REQ-028 Macro DATA_MEMORY_INIT_TABLE_EN defined: INIT SHALL load words 0..7 with 11,22,44,66,88,AA,CC,FF (hex) and all other words with 0.
REQ-029 Macro undefined: INIT SHALL load every word with 0.

Structure
REQ-030 Package dmem_pkg SHALL hold OP_LOAD (4'b1110), FSM state typedef, and the 8-entry init table constant.
REQ-031 Init counter and INIT/RUN FSM SHALL be a sub-module dmem_init_ctrl; storage array and response pipeline remain in the top.

Verification
REQ-032 Reset 1 cycle, release -> init_busy high and req_ready low for exactly 256 cycles, then req_ready=1.
REQ-033 With INIT_TABLE_EN, load addr 7 -> rsp_data=FF one cycle later; without it -> 00.
REQ-034 Store 5A to addr 20, next cycle load addr 20 with dest_reg=3, reg_we=1 -> rsp_data=5A, rsp_dest=3, rsp_reg_we=1.
REQ-035 Non-load opcode 0001, alu_result=C3 -> rsp_data=C3, memory unchanged.
REQ-036 Reset asserted during a 4-request burst -> rsp_valid=0 next cycle, init restarts at word 0, prior stores erased.
REQ-037 DEPTH=16, ADDR_W=8: store to addr 40 then load addr 40 -> rsp_data=00; words 0..15 unaffected.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared opcode, FSM state type and power-on init table for data_memory_pipe.
package dmem_pkg;

    localparam logic [3:0] OP_LOAD = 4'b1110;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } dmem_state_e;

    localparam int unsigned INIT_TABLE_N = 8;

    // Word 0 sits in the low byte.
    localparam logic [8*8-1:0] INIT_TABLE = {
        8'hFF, 8'hCC, 8'hAA, 8'h88, 8'h66, 8'h44, 8'h22, 8'h11
    };

    function automatic logic [7:0] init_table_word(input logic [2:0] idx);
        return INIT_TABLE[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dmem_init_ctrl.sv
// dmem_init_ctrl: INIT/RUN sequencer that walks every memory word once after reset.
module dmem_init_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output dmem_state_e       state
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    dmem_state_e       state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    // State and counter register; reset restarts initialisation from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: one word per INIT cycle, leave after the last word is written.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_we    = 1'b0;
        unique case (state)
            ST_INIT: begin
                init_we = !reset;
                if (cnt == LAST_WORD) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign init_addr = cnt;

endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: word memory with one-cycle registered load/passthrough response.
// Optional macro DATA_MEMORY_INIT_TABLE_EN preloads words 0..7 from the init table.
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        opcode,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        dest_reg,
    input  logic              reg_we,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_dest,
    output logic              rsp_reg_we,
    output logic              init_busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    dmem_state_e       state;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] rd_data;

    dmem_init_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .state     (state)
    );

    assign init_busy = (state == ST_INIT);
    assign req_ready = (state == ST_RUN);
    // A request arriving alongside reset is dropped so it cannot store into memory.
    assign accept    = req_valid && req_ready && !reset;
    assign in_range  = (32'(addr) < DEPTH);
    assign rd_data   = in_range ? mem[IDX_W'(addr)] : '0;

    // Value written to each word while initialising.
    always_comb begin
        init_data = '0;
`ifdef DATA_MEMORY_INIT_TABLE_EN
        if (32'(init_addr) < INIT_TABLE_N) begin
            init_data = DATA_W'(init_table_word(3'(init_addr)));
        end
`endif
    end

    // Storage: init sweep writes during INIT, accepted in-range stores during RUN.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[IDX_W'(init_addr)] <= init_data;
        end else if (accept && mem_we && in_range) begin
            mem[IDX_W'(addr)] <= wdata;
        end
    end

    // Response stage: loads read pre-write data because the store lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_dest   <= '0;
            rsp_reg_we <= 1'b0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= (opcode == OP_LOAD) ? rd_data : alu_result;
            rsp_dest   <= dest_reg;
            rsp_reg_we <= reg_we;
        end else begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
